// File: rtl/tsc_pkg.sv
// ============================================================================
// Module      : tsc_pkg
// Description : Shared constants for the ADC share arbiter and its requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tsc_pkg;

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_adc_req = 2'd1;
    localparam logic [1:0] c_st_deliver = 2'd2;
    localparam logic [1:0] c_st_adc_rel = 2'd3;

    localparam int c_default_dw      = 8;
    localparam int c_default_timeout = 64;

endpackage

`default_nettype wire

// File: rtl/adc_share_arbiter_if.sv
// ============================================================================
// Module      : adc_share_arbiter_if
// Description : Requester-side and ADC-side handshake bundle of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adc_share_arbiter_if
    import tsc_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int DW   = c_default_dw
);

    localparam int c_gw = $clog2(NREQ);

    logic [NREQ-1:0] req_i;
    logic [NREQ-1:0] rdy_o;
    logic [DW-1:0]   dat_o;
    logic            adc_req;
    logic            adc_rdy;
    logic [DW-1:0]   adc_dat;
    logic [c_gw-1:0] gnt_idx;
    logic            busy;
    logic            timeout_err;

    // slave = arbiter side, master = requesters plus ADC
    modport slave (
        input  req_i, adc_rdy, adc_dat,
        output rdy_o, dat_o, adc_req, gnt_idx, busy, timeout_err
    );

    modport master (
        output req_i, adc_rdy, adc_dat,
        input  rdy_o, dat_o, adc_req, gnt_idx, busy, timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/adc_share_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; searches ptr+1, ptr+2, ...
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Walk from farthest to nearest so the nearest set bit is the final write.
        for (int i = N; i >= 1; i--) begin
            logic [W-1:0] cand;
            cand = W'((int'(ptr) + i) % N);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_share_arbiter.sv
// ============================================================================
// Module      : adc_share_arbiter
// Description : Round-robin sharing of one req/rdy/dat ADC among NREQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_share_arbiter
    import tsc_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = c_default_dw,
    parameter int TIMEOUT = c_default_timeout
) (
    input  logic               clk,
    input  logic               reset,
    adc_share_arbiter_if.slave bus
);

    localparam int              c_gw       = $clog2(NREQ);
    localparam int              c_cw       = $clog2(TIMEOUT);
    localparam logic [c_cw-1:0] c_tmo_last = c_cw'(TIMEOUT - 1);
    localparam logic [c_gw-1:0] c_ptr_rst  = c_gw'(NREQ - 1);
    localparam logic [NREQ-1:0] c_one      = {{(NREQ-1){1'b0}}, 1'b1};

    logic [1:0]      r_state;
    logic [c_gw-1:0] r_ptr;
    logic [c_gw-1:0] r_gnt;
    logic [c_cw-1:0] r_cnt;
    logic            r_adc_req;
    logic [NREQ-1:0] r_rdy;
    logic [DW-1:0]   r_dat;
    logic            r_busy;
    logic            r_tmo;

    logic [c_gw-1:0] w_win;
    logic            w_win_vld;

    rr_pick #(
        .N (NREQ),
        .W (c_gw)
    ) u_rr_pick (
        .req   (bus.req_i),
        .ptr   (r_ptr),
        .idx   (w_win),
        .valid (w_win_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_ptr     <= c_ptr_rst;
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_adc_req <= 1'b0;
            r_rdy     <= '0;
            r_dat     <= '0;
            r_busy    <= 1'b0;
            r_tmo     <= 1'b0;
        end else begin
            r_tmo <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_win_vld) begin
                        r_gnt     <= w_win;
                        r_adc_req <= 1'b1;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= c_st_adc_req;
                    end
                end
                c_st_adc_req: begin
                    if (bus.adc_rdy) begin
                        r_dat     <= bus.adc_dat;
                        r_rdy     <= c_one << r_gnt;
                        r_adc_req <= 1'b0;
                        r_state   <= c_st_deliver;
                    end else if (r_cnt == c_tmo_last) begin
                        // Abort without delivering; the requester retries by holding req.
                        r_adc_req <= 1'b0;
                        r_tmo     <= 1'b1;
                        r_ptr     <= r_gnt;
                        r_state   <= c_st_adc_rel;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                c_st_deliver: begin
                    if (!bus.req_i[r_gnt] && !bus.adc_rdy) begin
                        r_rdy   <= '0;
                        r_ptr   <= r_gnt;
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                c_st_adc_rel: begin
                    // A late rdy after a timeout must clear before the ADC is reused.
                    if (!bus.adc_rdy) begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_adc_req <= 1'b0;
                    r_rdy     <= '0;
                    r_busy    <= 1'b0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.adc_req     = r_adc_req;
    assign bus.rdy_o       = r_rdy;
    assign bus.dat_o       = r_dat;
    assign bus.gnt_idx     = r_gnt;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_tmo;

endmodule

`default_nettype wire

// File: tb/tb_adc_share_arbiter.sv
// ============================================================================
// Module      : tb_adc_share_arbiter
// Description : Self-checking bench for adc_share_arbiter with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_share_arbiter;

    localparam int NREQ    = 2;
    localparam int DW      = 8;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    adc_share_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus();

    adc_share_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int m_last   = NREQ - 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: next winner is the first pending requester after the last one served.
    function automatic int model_pick(input logic [NREQ-1:0] pend, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (((pend >> ((last + k) % NREQ)) & NREQ'(1)) != '0) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        bus.req_i   = '0;
        bus.adc_rdy = 1'b0;
        bus.adc_dat = '0;
        reset       = 1'b1;
        tick();
        reset  = 1'b0;
        m_last = NREQ - 1;
    endtask

    // ADC behaviour for one granted transaction; the winner drops its request on rdy.
    task automatic adc_cycle(input int delay, input logic [DW-1:0] d, output int g,
                             output logic [NREQ-1:0] rdy_seen, output logic [DW-1:0] dat_seen,
                             output logic [NREQ-1:0] rdy_after, output bit ok);
        int w = 0;
        ok = 1'b1; g = -1; rdy_seen = '0; dat_seen = '0; rdy_after = '1;
        while (bus.adc_req !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (bus.adc_req !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        g = int'(bus.gnt_idx);
        repeat (delay) tick();
        bus.adc_rdy = 1'b1;
        bus.adc_dat = d;
        tick();
        rdy_seen    = bus.rdy_o;
        dat_seen    = bus.dat_o;
        bus.adc_rdy = 1'b0;
        bus.req_i   = bus.req_i & ~(NREQ'(1) << g);
        tick();
        rdy_after = bus.rdy_o;
    endtask

    task automatic test_reset();
        bus.req_i = '0; bus.adc_rdy = 1'b0; bus.adc_dat = 8'hff;
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.adc_req !== 1'b0) begin n_fail++; $display("FAIL reset_adc_req: got %0h want 0", bus.adc_req); end
        n_checks++; if (bus.rdy_o !== '0) begin n_fail++; $display("FAIL reset_rdy: got %0h want 0", bus.rdy_o); end
        n_checks++; if (bus.dat_o !== '0) begin n_fail++; $display("FAIL reset_dat: got %0h want 0", bus.dat_o); end
        n_checks++; if (bus.gnt_idx !== '0) begin n_fail++; $display("FAIL reset_gnt: got %0h want 0", bus.gnt_idx); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0h want 0", bus.busy); end
        n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr: got %0h want 0", bus.timeout_err); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.req_i = 2'b01;
        tick();
        n_checks++; if (bus.adc_req !== 1'b1 || bus.gnt_idx !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL single_grant: adc_req=%0h gnt=%0h busy=%0h want 1/0/1", bus.adc_req, bus.gnt_idx, bus.busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.adc_req !== 1'b1 || bus.rdy_o !== 2'b00) begin
                n_fail++; $display("FAIL single_wait: adc_req=%0h rdy=%0h want 1/0", bus.adc_req, bus.rdy_o); end
        end
        bus.adc_rdy = 1'b1; bus.adc_dat = 8'hd0;
        tick();
        n_checks++; if (bus.rdy_o !== 2'b01 || bus.dat_o !== 8'hd0 || bus.adc_req !== 1'b0) begin
            n_fail++; $display("FAIL single_deliver: rdy=%0h dat=%0h adc_req=%0h want 1/d0/0", bus.rdy_o, bus.dat_o, bus.adc_req); end
        bus.adc_rdy = 1'b0; bus.req_i = 2'b00;
        tick();
        n_checks++; if (bus.rdy_o !== 2'b00 || bus.busy !== 1'b0 || bus.dat_o !== 8'hd0) begin
            n_fail++; $display("FAIL single_release: rdy=%0h busy=%0h dat=%0h want 0/0/d0", bus.rdy_o, bus.busy, bus.dat_o); end
    endtask

    task automatic test_fairness();
        int g; bit ok; logic [NREQ-1:0] rs, ra; logic [DW-1:0] ds, d;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.req_i = 2'b11;
            d = DW'($urandom);
            adc_cycle($urandom_range(0, TIMEOUT - 2), d, g, rs, ds, ra, ok);
            n_checks++; if (!ok || g != i % 2 || rs !== (NREQ'(1) << (i % 2)) || ds !== d) begin
                n_fail++; $display("FAIL fair_%0d: ok=%0d gnt=%0d rdy=%0h dat=%0h want gnt=%0d dat=%0h", i, ok, g, rs, ds, i % 2, d); end
        end
        bus.req_i = '0;
        tick();
    endtask

    task automatic test_timeout();
        int cnt = 0; bit seen_rdy = 0, terr_early = 0;
        int g; bit ok; logic [NREQ-1:0] rs, ra; logic [DW-1:0] ds;
        do_reset();
        bus.req_i = 2'b11;
        tick();
        n_checks++; if (bus.adc_req !== 1'b1 || bus.gnt_idx !== 1'b0) begin
            n_fail++; $display("FAIL tmo_grant: adc_req=%0h gnt=%0h want 1/0", bus.adc_req, bus.gnt_idx); end
        while (bus.adc_req === 1'b1 && cnt < 20) begin
            cnt++;
            if (bus.rdy_o !== '0) seen_rdy = 1;
            if (bus.timeout_err !== 1'b0) terr_early = 1;
            tick();
        end
        n_checks++; if (cnt != TIMEOUT) begin n_fail++; $display("FAIL tmo_len: got %0d want %0d", cnt, TIMEOUT); end
        n_checks++; if (bus.timeout_err !== 1'b1 || terr_early) begin
            n_fail++; $display("FAIL tmo_pulse: terr=%0h early=%0d want 1/0", bus.timeout_err, terr_early); end
        n_checks++; if (seen_rdy || bus.rdy_o !== '0) begin n_fail++; $display("FAIL tmo_rdy: seen=%0d rdy=%0h want 0", seen_rdy, bus.rdy_o); end
        bus.adc_rdy = 1'b1;
        tick();
        n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_one_cycle: got %0h want 0", bus.timeout_err); end
        tick();
        tick();
        n_checks++; if (bus.busy !== 1'b1 || bus.adc_req !== 1'b0 || bus.rdy_o !== '0) begin
            n_fail++; $display("FAIL tmo_late_rdy: busy=%0h adc_req=%0h rdy=%0h want 1/0/0", bus.busy, bus.adc_req, bus.rdy_o); end
        bus.adc_rdy = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL tmo_release: busy=%0h want 0", bus.busy); end
        adc_cycle(2, 8'h3c, g, rs, ds, ra, ok);
        n_checks++; if (!ok || g != 1 || rs !== 2'b10 || ds !== 8'h3c) begin
            n_fail++; $display("FAIL tmo_other: ok=%0d gnt=%0d rdy=%0h dat=%0h want 1/2/3c", ok, g, rs, ds); end
        adc_cycle(1, 8'hc3, g, rs, ds, ra, ok);
        n_checks++; if (!ok || g != 0 || rs !== 2'b01 || ds !== 8'hc3) begin
            n_fail++; $display("FAIL tmo_retry: ok=%0d gnt=%0d rdy=%0h dat=%0h want 0/1/c3", ok, g, rs, ds); end
    endtask

    task automatic test_reset_mid();
        int g; bit ok; logic [NREQ-1:0] rs, ra; logic [DW-1:0] ds;
        do_reset();
        bus.req_i = 2'b01;
        adc_cycle(0, 8'h11, g, rs, ds, ra, ok);
        bus.req_i = 2'b10;
        tick();
        n_checks++; if (bus.gnt_idx !== 1'b1 || bus.adc_req !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pre: gnt=%0h adc_req=%0h want 1/1", bus.gnt_idx, bus.adc_req); end
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (bus.adc_req !== 1'b0 || bus.rdy_o !== '0 || bus.busy !== 1'b0 || bus.gnt_idx !== 1'b0) begin
            n_fail++; $display("FAIL rmid_reset: adc_req=%0h rdy=%0h busy=%0h gnt=%0h want 0/0/0/0", bus.adc_req, bus.rdy_o, bus.busy, bus.gnt_idx); end
        reset = 1'b0;
        bus.req_i = 2'b11;
        tick();
        n_checks++; if (bus.gnt_idx !== 1'b0 || bus.adc_req !== 1'b1) begin
            n_fail++; $display("FAIL rmid_next: gnt=%0h adc_req=%0h want 0/1", bus.gnt_idx, bus.adc_req); end
        adc_cycle(1, 8'h22, g, rs, ds, ra, ok);
        bus.req_i = '0;
        tick();
        tick();
    endtask

    task automatic test_early_drop();
        do_reset();
        bus.req_i = 2'b10;
        tick();
        n_checks++; if (bus.adc_req !== 1'b1 || bus.gnt_idx !== 1'b1) begin
            n_fail++; $display("FAIL drop_grant: adc_req=%0h gnt=%0h want 1/1", bus.adc_req, bus.gnt_idx); end
        bus.req_i = 2'b00;
        tick();
        tick();
        bus.adc_rdy = 1'b1; bus.adc_dat = 8'h55;
        tick();
        n_checks++; if (bus.rdy_o !== 2'b10 || bus.dat_o !== 8'h55) begin
            n_fail++; $display("FAIL drop_deliver: rdy=%0h dat=%0h want 2/55", bus.rdy_o, bus.dat_o); end
        tick();
        n_checks++; if (bus.rdy_o !== 2'b10 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL drop_hold: rdy=%0h busy=%0h want 2/1", bus.rdy_o, bus.busy); end
        bus.adc_rdy = 1'b0;
        tick();
        n_checks++; if (bus.rdy_o !== 2'b00 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_idle: rdy=%0h busy=%0h want 0/0", bus.rdy_o, bus.busy); end
    endtask

    task automatic test_random();
        int g, exp; bit ok; logic [NREQ-1:0] rs, ra, pend; logic [DW-1:0] ds, d;
        do_reset();
        pend = '0;
        for (int i = 0; i < 16; i++) begin
            pend = pend | NREQ'($urandom_range(1, (1 << NREQ) - 1));
            bus.req_i = pend;
            exp = model_pick(pend, m_last);
            d = DW'($urandom);
            adc_cycle($urandom_range(0, TIMEOUT - 2), d, g, rs, ds, ra, ok);
            n_checks++; if (!ok || g != exp || rs !== (NREQ'(1) << exp) || ds !== d || ra !== '0) begin
                n_fail++; $display("FAIL rand_%0d: ok=%0d gnt=%0d rdy=%0h dat=%0h after=%0h want gnt=%0d dat=%0h",
                                   i, ok, g, rs, ds, ra, exp, d); end
            pend   = pend & ~(NREQ'(1) << exp);
            m_last = exp;
        end
        bus.req_i = '0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.req_i = '0; bus.adc_rdy = 1'b0; bus.adc_dat = '0;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_early_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
